// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_ctrl
//  Description : Instruction fetch controller for the filter processor.
//                Owns the program counter, presents instructions to the
//                decoder through a valid/ready handshake, handles branch
//                redirects and halt detection, and lends the memory port to
//                a host loader between runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 16,
    parameter int                MEM_DEPTH = 16,
    parameter logic [INST_W-1:0] HALT_INST = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [INST_W-1:0] mem_wdata,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_RUN  = 3'd2;
    localparam logic [2:0] c_ST_HALT = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;

    localparam logic [ADDR_W-1:0] c_MEM_DEPTH = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP   = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_err;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [INST_W-1:0] w_inst_nxt;
    logic [ADDR_W-1:0] w_inst_pc_nxt;
    logic              w_inst_valid_nxt;
    logic              w_err_nxt;

    logic              w_load_in_range;
    logic              w_pc_in_range;
    logic              w_tgt_in_range;
    logic              w_fetch_en;

    assign w_load_in_range = (load_addr < c_MEM_DEPTH);
    assign w_pc_in_range   = (r_pc < c_MEM_DEPTH);
    assign w_tgt_in_range  = (br_target < c_MEM_DEPTH);
    // A branch always wins over a fetch in the same cycle.
    assign w_fetch_en      = (!r_inst_valid || inst_ready) && !br_taken;

    // Memory port mux: host drives address/data while loading, PC otherwise.
    assign mem_addr  = (r_state == c_ST_LOAD) ? load_addr : r_pc;
    assign mem_wdata = load_data;
    assign mem_we    = (r_state == c_ST_LOAD) && load_en && load_we && w_load_in_range;

    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign err        = r_err;
    assign busy       = (r_state == c_ST_RUN);
    assign halted     = (r_state == c_ST_HALT);

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_err_nxt        = r_err;

        case (r_state)
            c_ST_IDLE, c_ST_HALT, c_ST_ERR: begin
                w_inst_valid_nxt = 1'b0;
                if (r_state == c_ST_ERR) begin
                    w_err_nxt = 1'b1;
                end
                if (load_en) begin
                    w_state_nxt = c_ST_LOAD;
                end else if (start) begin
                    w_state_nxt = c_ST_RUN;
                    w_pc_nxt    = '0;
                    w_err_nxt   = 1'b0;
                end
            end

            c_ST_LOAD: begin
                w_inst_valid_nxt = 1'b0;
                if (!load_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!w_load_in_range) begin
                    w_err_nxt = 1'b1;
                end
            end

            c_ST_RUN: begin
                if (br_taken) begin
                    // Flush the wrong-path instruction and redirect.
                    w_inst_valid_nxt = 1'b0;
                    w_pc_nxt         = br_target;
                    if (!w_tgt_in_range) begin
                        w_state_nxt = c_ST_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end else if (w_fetch_en) begin
                    if (!w_pc_in_range) begin
                        w_state_nxt      = c_ST_ERR;
                        w_err_nxt        = 1'b1;
                        w_inst_valid_nxt = 1'b0;
                    end else if (mem_rdata == HALT_INST) begin
                        // Halt word is swallowed; pc stays on it.
                        w_state_nxt      = c_ST_HALT;
                        w_inst_valid_nxt = 1'b0;
                    end else begin
                        w_inst_nxt       = mem_rdata;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + c_PC_STEP;
                    end
                end
            end

            default: begin
                w_state_nxt      = c_ST_IDLE;
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_pc         <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_ctrl
//  Description : Self-checking bench for inst_fetch_ctrl with a behavioural
//                16-word instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        load_en;
    logic        load_we;
    logic [31:0] load_addr;
    logic [15:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        err;

    inst_fetch_ctrl #(
        .ADDR_W    (32),
        .INST_W    (16),
        .MEM_DEPTH (16),
        .HALT_INST (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_en    (load_en),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory: combinational read, clocked write.
    logic [15:0] mem [0:15];
    assign mem_rdata = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 16'h0000;
    always @(posedge clk) begin
        if (mem_we && (mem_addr < 32'd16)) mem[mem_addr[3:0]] <= mem_wdata;
    end

    // The halt word must never be presented as a valid instruction.
    logic r_halt_leak;
    initial r_halt_leak = 1'b0;
    always @(negedge clk) begin
        if (rst_n && inst_valid && (inst == 16'hFFFF)) r_halt_leak = 1'b1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic le, input logic we, input logic [31:0] a,
                         input logic [15:0] d, input logic rdy, input logic br, input logic [31:0] tgt);
        start = st; load_en = le; load_we = we; load_addr = a; load_data = d;
        inst_ready = rdy; br_taken = br; br_target = tgt;
    endtask

    typedef struct {
        logic        st, le, we;
        logic [31:0] a;
        logic [15:0] d;
        logic        rdy, br;
        logic [31:0] tgt;
        logic        e_we;
        logic        e_v;
        logic [15:0] e_inst;
        logic [31:0] e_ipc, e_pc;
        logic        e_busy, e_halt, e_err;
    } vec_t;

    vec_t tbl [64];
    int   n_vec = 0;

    task automatic add(input logic st, input logic le, input logic we, input logic [31:0] a,
                       input logic [15:0] d, input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic e_we, input logic e_v, input logic [15:0] e_inst,
                       input logic [31:0] e_ipc, input logic [31:0] e_pc,
                       input logic e_busy, input logic e_halt, input logic e_err);
        tbl[n_vec] = '{st, le, we, a, d, rdy, br, tgt, e_we, e_v, e_inst, e_ipc, e_pc, e_busy, e_halt, e_err};
        n_vec++;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.pc", pc, 0);
        chk("rst.inst", {16'h0, inst}, 0);
        chk("rst.inst_pc", inst_pc, 0);
        chk("rst.inst_valid", {31'h0, inst_valid}, 0);
        chk("rst.mem_we", {31'h0, mem_we}, 0);
        chk("rst.err", {31'h0, err}, 0);
        chk("rst.busy", {31'h0, busy}, 0);
        chk("rst.halted", {31'h0, halted}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- load + run, out-of-range load write, start/load priority ----
        //   st le we addr data     rdy br tgt | we v inst      ipc pc busy halt err
        add(1, 1, 0, 0,  16'h0000, 0, 0, 0,    0,  0, 16'h0000, 0, 0, 0, 0, 0);
        add(1, 1, 1, 20, 16'h1234, 0, 0, 0,    0,  0, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0,  16'hA001, 0, 0, 0,    1,  0, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1,  16'hA002, 0, 0, 0,    1,  0, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 1, 1, 2,  16'hFFFF, 0, 0, 0,    1,  0, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,    0,  0, 16'h0000, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  0, 16'h0000, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hA001, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hA002, 1, 2, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  0, 16'hA002, 1, 2, 0, 1, 0);
        // ---- restart from HALT with backpressure ----
        add(1, 0, 0, 0,  16'h0000, 0, 0, 0,    0,  0, 16'hA002, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,    0,  1, 16'hA001, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hA001, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hA002, 1, 2, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,    0,  1, 16'hA002, 1, 2, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  0, 16'hA002, 1, 2, 0, 1, 0);
        // ---- branch: B000, B001, redirect to 4, B004, B005, halt ----
        add(0, 1, 0, 0,  16'h0000, 0, 0, 0,    0,  0, 16'hA002, 1, 2, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            add(0, 1, 1, 32'(k), 16'hB000 + 16'(k), 0, 0, 0, 1, 0, 16'hA002, 1, 2, 0, 0, 0);
        add(0, 1, 1, 6,  16'hFFFF, 0, 0, 0,    1,  0, 16'hA002, 1, 2, 0, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,    0,  0, 16'hA002, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  0, 16'hA002, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hB000, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hB001, 1, 2, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 1, 4,    0,  0, 16'hB001, 1, 4, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hB004, 4, 5, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  1, 16'hB005, 5, 6, 1, 0, 0);
        add(0, 0, 0, 0,  16'h0000, 1, 0, 0,    0,  0, 16'hB005, 5, 6, 0, 1, 0);

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].st, tbl[i].le, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
            #1;
            chk($sformatf("v%0d.mem_we", i), {31'h0, mem_we}, {31'h0, tbl[i].e_we});
            tick();
            chk($sformatf("v%0d.inst_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_v});
            chk($sformatf("v%0d.inst", i), {16'h0, inst}, {16'h0, tbl[i].e_inst});
            chk($sformatf("v%0d.inst_pc", i), inst_pc, tbl[i].e_ipc);
            chk($sformatf("v%0d.pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d.busy", i), {31'h0, busy}, {31'h0, tbl[i].e_busy});
            chk($sformatf("v%0d.halted", i), {31'h0, halted}, {31'h0, tbl[i].e_halt});
            chk($sformatf("v%0d.err", i), {31'h0, err}, {31'h0, tbl[i].e_err});
        end

        // ---- run off the end of memory with no halt word ----
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 32'(i), 16'hC000 + 16'(i), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        start = 1'b0;
        chk("oor.start_busy", {31'h0, busy}, 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("oor.valid%0d", i), {31'h0, inst_valid}, 1);
            chk($sformatf("oor.inst%0d", i), {16'h0, inst}, {16'h0, 16'hC000 + 16'(i)});
            chk($sformatf("oor.ipc%0d", i), inst_pc, 32'(i));
        end
        tick();
        chk("oor.err", {31'h0, err}, 1);
        chk("oor.inst_valid", {31'h0, inst_valid}, 0);
        chk("oor.busy", {31'h0, busy}, 0);
        chk("oor.halted", {31'h0, halted}, 0);

        // ---- restart from ERR, then branch out of range ----
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        start = 1'b0;
        chk("errrestart.err", {31'h0, err}, 0);
        chk("errrestart.busy", {31'h0, busy}, 1);
        chk("errrestart.pc", pc, 0);
        tick();
        chk("errrestart.inst", {16'h0, inst}, {16'h0, 16'hC000});
        br_taken = 1'b1; br_target = 32'd16;
        tick();
        br_taken = 1'b0;
        chk("br16.err", {31'h0, err}, 1);
        chk("br16.busy", {31'h0, busy}, 0);
        chk("br16.inst_valid", {31'h0, inst_valid}, 0);

        // ---- asynchronous reset in the middle of a run ----
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("prereset.pc", pc, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.pc", pc, 0);
        chk("arst.inst", {16'h0, inst}, 0);
        chk("arst.inst_pc", inst_pc, 0);
        chk("arst.inst_valid", {31'h0, inst_valid}, 0);
        chk("arst.busy", {31'h0, busy}, 0);
        chk("arst.err", {31'h0, err}, 0);
        chk("arst.mem_we", {31'h0, mem_we}, 0);
        chk("arst.mem_addr", mem_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        chk("halt_never_forwarded", {31'h0, r_halt_leak}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
